// File: rtl/cdb_pkg.sv
// Shared types and defaults for the common-data-bus broadcaster.
package cdb_pkg;

  localparam int unsigned CDB_WIDTH      = 31;
  localparam int unsigned CDB_ROB        = 2;
  localparam int unsigned CDB_NUM_FU     = 3;
  localparam int unsigned CDB_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_BRANCH = 2'd1,
    FU_LSU    = 2'd2
  } fu_id_e;

  typedef struct packed {
    logic [CDB_WIDTH:0] result;
    logic [CDB_ROB:0]   robEntry;
  } cdb_entry_t;

  // Index width for a population of n sources; never zero.
  function automatic int unsigned src_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// FU result handshake and CDB broadcast bundle; master = FU/ROB side, slave = broadcaster.
interface cdb_broadcaster_if
  import cdb_pkg::*;
#(
  parameter int unsigned WIDTH  = CDB_WIDTH,
  parameter int unsigned ROB    = CDB_ROB,
  parameter int unsigned NUM_FU = CDB_NUM_FU
) ();

  localparam int unsigned SRC_W = src_width(NUM_FU);

  logic [NUM_FU-1:0]            fu_valid;
  logic [NUM_FU-1:0][WIDTH:0]   fu_result;
  logic [NUM_FU-1:0][ROB:0]     fu_rob;
  logic [NUM_FU-1:0]            fu_ready;

  logic [WIDTH:0]               cdb_result;
  logic [ROB:0]                 cdb_robEntry;
  logic                         cdb_validBroadcast;
  logic [SRC_W-1:0]             cdb_src;

  modport master (
    output fu_valid, fu_result, fu_rob,
    input  fu_ready, cdb_result, cdb_robEntry, cdb_validBroadcast, cdb_src
  );

  modport slave (
    input  fu_valid, fu_result, fu_rob,
    output fu_ready, cdb_result, cdb_robEntry, cdb_validBroadcast, cdb_src
  );

endinterface

// File: rtl/cdb_result_fifo.sv
// Single-clock result FIFO for one functional unit; pointers wrap, count is one bit wider.
module cdb_result_fifo
  import cdb_pkg::*;
#(
  parameter type         entry_t = cdb_entry_t,
  parameter int unsigned DEPTH   = CDB_FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   clear_n,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  logic            push_ok;
  logic            pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: count gates every read of head.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmitter: per-FU result FIFOs, round-robin grant, one registered broadcast per cycle.
// Define CDB_BYPASS_EN to let an idle FU's incoming result skip its FIFO when it wins the grant.
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int unsigned WIDTH      = CDB_WIDTH,
  parameter int unsigned ROB        = CDB_ROB,
  parameter int unsigned NUM_FU     = CDB_NUM_FU,
  parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              flush,
  cdb_broadcaster_if.slave  bus
);

  localparam int unsigned SRC_W = src_width(NUM_FU);

  typedef struct packed {
    logic [WIDTH:0] result;
    logic [ROB:0]   robEntry;
  } entry_t;

  entry_t              head [NUM_FU];
  logic [NUM_FU-1:0]   empty;
  logic [NUM_FU-1:0]   full;
  logic [NUM_FU-1:0]   push;
  logic [NUM_FU-1:0]   pop;
  logic [NUM_FU-1:0]   take_input;
  logic [NUM_FU-1:0]   cand;

  logic [SRC_W-1:0]    rr_ptr;
  logic [SRC_W-1:0]    scan_idx;
  logic [SRC_W-1:0]    grant_idx;
  logic                grant_any;
  entry_t              grant_entry;

  logic                out_valid;
  logic [WIDTH:0]      out_result;
  logic [ROB:0]        out_rob;
  logic [SRC_W-1:0]    out_src;

  assign bus.fu_ready = ~full;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    logic granted;
    assign granted = grant_any && (grant_idx == SRC_W'(i)) && !flush;

`ifdef CDB_BYPASS_EN
    assign cand[i]       = !empty[i] || bus.fu_valid[i];
    assign take_input[i] = granted && empty[i];
`else
    assign cand[i]       = !empty[i];
    assign take_input[i] = 1'b0;
`endif

    assign push[i] = bus.fu_valid[i] && !full[i] && !flush && !take_input[i];
    assign pop[i]  = granted && !empty[i];

    cdb_result_fifo #(
      .entry_t (entry_t),
      .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .clear_n (clear_n),
      .flush   (flush),
      .push    (push[i]),
      .pop     (pop[i]),
      .din     ({bus.fu_result[i], bus.fu_rob[i]}),
      .head    (head[i]),
      .empty   (empty[i]),
      .full    (full[i])
    );
  end

  // Circular search starting one past the last granted FU.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= NUM_FU; k++) begin
      scan_idx = SRC_W'((32'(rr_ptr) + k) % NUM_FU);
      if (!grant_any && cand[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    grant_entry = head[grant_idx];
`ifdef CDB_BYPASS_EN
    if (empty[grant_idx]) begin
      grant_entry.result   = bus.fu_result[grant_idx];
      grant_entry.robEntry = bus.fu_rob[grant_idx];
    end
`endif
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rob    <= '0;
      out_src    <= '0;
      rr_ptr     <= SRC_W'(NUM_FU - 1);
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (grant_any) begin
      out_valid  <= 1'b1;
      out_result <= grant_entry.result;
      out_rob    <= grant_entry.robEntry;
      out_src    <= grant_idx;
      rr_ptr     <= grant_idx;
    end else begin
      out_valid  <= 1'b0;
    end
  end

  assign bus.cdb_validBroadcast = out_valid;
  assign bus.cdb_result         = out_result;
  assign bus.cdb_robEntry       = out_rob;
  assign bus.cdb_src            = out_src;

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Transmitter side of the common data bus; the reservation-station entries are the receivers.
- Collects completed results from the functional units (ALU, branch, load/store), buffers each unit's results in a small FIFO, and arbitrates round-robin.
- Drives exactly one registered broadcast per cycle: result value, ROB tag and validBroadcast. The reservation stations and ROB snoop this broadcast.

Parameters:
- WIDTH, 31, MSB index of result data (data is WIDTH+1 bits).
- ROB, 2, MSB index of the ROB tag (tag is ROB+1 bits).
- NUM_FU, 3, number of functional-unit result ports.
- FIFO_DEPTH, 2, entries per FU result FIFO; must be a power of two, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash (mispredict recovery). Discards all buffered and incoming results.
- fu_valid  in  NUM_FU  per-FU result valid.
- fu_result  in  NUM_FU x (WIDTH+1)  per-FU result value.
- fu_rob  in  NUM_FU x (ROB+1)  per-FU destination ROB tag.
- fu_ready  out  NUM_FU  per-FU buffer space available.
- cdb_result  out  WIDTH+1  broadcast value.
- cdb_robEntry  out  ROB+1  broadcast ROB tag.
- cdb_validBroadcast  out  1  broadcast qualifier.
- cdb_src  out  $clog2(NUM_FU)  index of the FU whose result is broadcast.

Behaviour:
- Reset (clear_n low, asynchronous):
  - All FIFOs empty.
  - cdb_validBroadcast=0, cdb_result=0, cdb_robEntry=0, cdb_src=0.
  - RR pointer=NUM_FU-1, so FU0 has top priority first.
  - fu_ready all ones.
- Handshake:
  - Transfer occurs when fu_valid[i] & fu_ready[i] at a rising edge.
  - fu_ready[i] = !full[i], computed combinationally from the registered count. There is no same-cycle pop-through, so a full FIFO deasserts ready even if it is popped in that cycle.
  - fu_valid while !fu_ready: value is ignored; the FU must hold it.
- Arbitration, every edge:
  - Candidates are FUs with a non-empty FIFO.
  - Grant the first candidate after the RR pointer, in circular search order.
  - Pop its head into the output registers and set cdb_validBroadcast=1. The RR pointer becomes the granted index.
  - No candidates: cdb_validBroadcast=0, data/tag/src hold their last values, pointer unchanged.
- Latency: a result accepted at edge N is broadcast at the earliest after edge N+1 (visible during cycle N+1 to N+2), if it wins arbitration.
- Broadcast lasts exactly one cycle; the same result is never re-broadcast.
- Simultaneous push and pop on one FIFO: both occur and the count is unchanged. Full plus pop plus valid is not possible, because ready=0.
- Ordering: per-FU order is preserved (FIFO). There is no ordering guarantee across FUs.
- Flush at edge N:
  - All FIFOs emptied.
  - Inputs presented in that cycle are dropped.
  - cdb_validBroadcast=0 after edge N.
  - RR pointer unchanged.
  - flush overrides arbitration in the same edge.
- Wrap-around: FIFO read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider.
- Reset mid-operation: everything is discarded immediately and no broadcast completes.

Optional Feature:
- CDB_BYPASS_EN defined:
  - An FU whose FIFO is empty and which asserts fu_valid with fu_ready is a candidate in the same cycle.
  - If granted, the result goes straight to the output registers and is not written to the FIFO. Latency is accepted at edge N, broadcast after edge N.
  - If not granted, it is pushed normally.
  - flush still drops it.
- CDB_BYPASS_EN undefined: behaviour exactly as above, minimum one cycle of FIFO residency.

Decomposition:
- Package cdb_pkg holds:
  - cdb_entry_t packed struct {result [WIDTH:0], robEntry [ROB:0]}.
  - Constants FU_ALU=0, FU_BRANCH=1, FU_LSU=2.
  - The default NUM_FU.
- Sub-module cdb_result_fifo: one-clock FIFO of cdb_entry_t with push/pop/flush, outputs head/empty/full.
- The RR arbiter and output registers stay in cdb_broadcaster.

Test Plan:
- Reset then single FU0 push (result 32'd30, rob 3'd4) → next cycle cdb_validBroadcast=1, cdb_result=30, cdb_robEntry=4, cdb_src=0. Following cycle validBroadcast=0.
- FU0, FU1 and FU2 all push in one cycle (rob 1, 2, 3) → broadcasts over three consecutive cycles in order src 0, 1, 2. A second simultaneous round broadcasts in order 0, 1, 2 again, confirming pointer rotation.
- FU1 pushes rob 5, 6, 7 on consecutive cycles while FU0 is kept busy → fu_ready[1] drops after two accepted results. No loss; rob 5, 6, 7 are broadcast in order.
- Two results buffered, flush asserted together with a new FU2 push (rob 3'd2) → no broadcast in the following cycles, fu_ready all ones, and rob 2 is never broadcast.
- clear_n pulsed low mid-burst → outputs zero asynchronously, and after release the first push is broadcast with src correct.
- With CDB_BYPASS_EN: idle bus, FU2 pushes result 32'd23, rob 3'd5 → broadcast visible in the cycle immediately after the accepting edge. Without the macro it appears one cycle later.
